// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared constants and FSM encoding for the operand SRAM banks.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int OP_DATA_W    = 48;
    localparam int OP_ADDR_W    = 9;
    localparam int OP_NUM_BANKS = 4;
    localparam int OP_CNT_W     = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FIN  = 2'd2
    } op_state_e;

endpackage
`default_nettype wire

// File: rtl/op_bank_stripe.sv
`default_nettype none
// ============================================================================
// Module      : op_bank_stripe
// Description : Maps a word index and base row to a one-hot bank select and
//               the bank row address (combinational, shared with read side).
// Revision    : 1.0 - initial release
// ============================================================================
module op_bank_stripe
    import mem_pkg::*;
#(
    parameter int ADDR_W = OP_ADDR_W,
    parameter int CNT_W  = OP_CNT_W
)(
    input  logic [CNT_W-1:0]        i_k,
    input  logic [ADDR_W-1:0]       i_base_addr,
    output logic [OP_NUM_BANKS-1:0] o_bank_sel,
    output logic [ADDR_W-1:0]       o_row_addr
);

    // Bank is k mod 4; row offset is k >> 2 truncated to the row width so it wraps.
    assign o_bank_sel = OP_NUM_BANKS'(1) << i_k[1:0];
    assign o_row_addr = i_base_addr + i_k[ADDR_W+1:2];

endmodule
`default_nettype wire

// File: rtl/op_bank_loader.sv
`default_nettype none
// ============================================================================
// Module      : op_bank_loader
// Description : Stripes a valid/ready stream of operand words round-robin
//               across the four operand SRAM banks with registered writes.
// Revision    : 1.0 - initial release
// ============================================================================
module op_bank_loader
    import mem_pkg::*;
#(
    parameter int DATA_W = OP_DATA_W,
    parameter int ADDR_W = OP_ADDR_W,
    parameter int CNT_W  = OP_CNT_W
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] op_reg,
    output logic              we1,
    output logic              we2,
    output logic              we3,
    output logic              we4,
    output logic [ADDR_W-1:0] write_addr1,
    output logic [ADDR_W-1:0] write_addr2,
    output logic [ADDR_W-1:0] write_addr3,
    output logic [ADDR_W-1:0] write_addr4,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    op_state_e                              r_state;
    op_state_e                              w_state_nxt;
    logic [CNT_W-1:0]                       r_num;
    logic [ADDR_W-1:0]                      r_base;
    logic [CNT_W-1:0]                       r_k;
    logic [DATA_W-1:0]                      r_op_reg;
    logic [OP_NUM_BANKS-1:0]                r_we;
    logic [OP_NUM_BANKS-1:0][ADDR_W-1:0]    r_waddr;

    logic                    w_in_ready;
    logic                    w_done;
    logic                    w_load_start;
    logic                    w_accept;
    logic                    w_last;
    logic [OP_NUM_BANKS-1:0] w_bank_sel;
    logic [ADDR_W-1:0]       w_row_addr;

    op_bank_stripe #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_stripe (
        .i_k         (r_k),
        .i_base_addr (r_base),
        .o_bank_sel  (w_bank_sel),
        .o_row_addr  (w_row_addr)
    );

    assign w_accept = in_valid & w_in_ready;
    assign w_last   = (r_k == (r_num - c_one));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_in_ready   = 1'b0;
        w_done       = 1'b0;
        w_load_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load_start = 1'b1;
                    w_state_nxt  = (num_words != '0) ? ST_LOAD : ST_FIN;
                end
            end
            ST_LOAD: begin
                w_in_ready = 1'b1;
                if (in_valid && w_last) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Write enables are one-cycle pulses; addresses and data hold between writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_num    <= '0;
            r_base   <= '0;
            r_k      <= '0;
            r_op_reg <= '0;
            r_we     <= '0;
            r_waddr  <= '0;
        end else begin
            r_we <= '0;
            if (w_load_start) begin
                r_num  <= num_words;
                r_base <= base_addr;
                r_k    <= '0;
            end
            if (w_accept) begin
                r_op_reg <= in_data;
                r_we     <= w_bank_sel;
                r_k      <= r_k + c_one;
                for (int b = 0; b < OP_NUM_BANKS; b++) begin
                    if (w_bank_sel[b]) begin
                        r_waddr[b] <= w_row_addr;
                    end
                end
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign done        = w_done;
    assign busy        = (r_state != ST_IDLE) & ~w_done;
    assign op_reg      = r_op_reg;
    assign we1         = r_we[0];
    assign we2         = r_we[1];
    assign we3         = r_we[2];
    assign we4         = r_we[3];
    assign write_addr1 = r_waddr[0];
    assign write_addr2 = r_waddr[1];
    assign write_addr3 = r_waddr[2];
    assign write_addr4 = r_waddr[3];

endmodule
`default_nettype wire
